// File: rtl/aes_round_stage.sv
// aes_round_stage: one elastic AES round (encrypt or decrypt per block) with a
// 2-entry output buffer (main register M + skid register S).
//
// Ports:
//   clk, rst        clock (rising edge), asynchronous active-low reset
//   flush           synchronous clear of all buffered blocks (wins over push/pop)
//   in_valid/ready  input handshake; in_ready depends only on registered state
//   in_data/in_key  round input state and round key
//   in_dec          0 = encrypt round, 1 = decrypt round
//   in_nomix        1 = skip MixColumns / InvMixColumns (first/last rounds)
//   in_tag          sideband carried with the block
//   out_valid/ready output handshake
//   out_data/out_tag round result and its tag; both 0 while out_valid = 0
module aes_round_stage #(
  parameter int unsigned BLOCK_LENGTH = 128,
  parameter int unsigned TAG_WIDTH    = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [BLOCK_LENGTH-1:0] in_data,
  input  logic [BLOCK_LENGTH-1:0] in_key,
  input  logic                    in_dec,
  input  logic                    in_nomix,
  input  logic [TAG_WIDTH-1:0]    in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [BLOCK_LENGTH-1:0] out_data,
  output logic [TAG_WIDTH-1:0]    out_tag
);

  if (BLOCK_LENGTH != 128) begin : g_bad_block_length
    $error("aes_round_stage: BLOCK_LENGTH must be 128");
  end
  if (TAG_WIDTH < 1) begin : g_bad_tag_width
    $error("aes_round_stage: TAG_WIDTH must be at least 1");
  end

  // ---------------------------------------------------------------------------
  // GF(2^8) arithmetic and byte transforms. Byte k of the state (FIPS-197
  // column-major order: row k%4, column k/4) sits at bits [127-8k -: 8].
  // ---------------------------------------------------------------------------
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ ({8{a[7]}} & 8'h1b);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0 as AES requires).
  function automatic logic [7:0] ginv(input logic [7:0] a);
    logic [7:0] r;
    logic [7:0] p;
    r = 8'h01;
    p = a;
    for (int unsigned i = 1; i < 8; i++) begin
      p = gmul(p, p);
      r = gmul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl(input logic [7:0] a, input int unsigned n);
    logic [15:0] d;
    d = {a, a};
    return d[15-n -: 8];
  endfunction

  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] v;
    v = ginv(a);
    return v ^ rotl(v, 1) ^ rotl(v, 2) ^ rotl(v, 3) ^ rotl(v, 4) ^ 8'h63;
  endfunction

  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    return ginv(rotl(a, 1) ^ rotl(a, 3) ^ rotl(a, 6) ^ 8'h05);
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    o = '0;
    for (int unsigned i = 0; i < 16; i++)
      o[127-8*i -: 8] = inv ? inv_sbox(s[127-8*i -: 8]) : sbox(s[127-8*i -: 8]);
    return o;
  endfunction

  // Row r rotates left by r (encrypt) or right by r (decrypt).
  function automatic logic [127:0] shift_rows(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    int unsigned  src;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      for (int unsigned r = 0; r < 4; r++) begin
        src = inv ? 4 * ((c + 4 - r) % 4) + r : 4 * ((c + r) % 4) + r;
        o[127-8*(4*c+r) -: 8] = s[127-8*src -: 8];
      end
    end
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s, input logic inv);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int unsigned c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      if (inv) begin
        o[127-32*c -: 8] = gmul(a0, 8'h0e) ^ gmul(a1, 8'h0b) ^ gmul(a2, 8'h0d) ^ gmul(a3, 8'h09);
        o[119-32*c -: 8] = gmul(a0, 8'h09) ^ gmul(a1, 8'h0e) ^ gmul(a2, 8'h0b) ^ gmul(a3, 8'h0d);
        o[111-32*c -: 8] = gmul(a0, 8'h0d) ^ gmul(a1, 8'h09) ^ gmul(a2, 8'h0e) ^ gmul(a3, 8'h0b);
        o[103-32*c -: 8] = gmul(a0, 8'h0b) ^ gmul(a1, 8'h0d) ^ gmul(a2, 8'h09) ^ gmul(a3, 8'h0e);
      end else begin
        o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
    end
    return o;
  endfunction

  // ---------------------------------------------------------------------------
  // Combinational round
  // ---------------------------------------------------------------------------
  logic [127:0] enc_sr, enc_mix, dec_ark, dec_mix, result;

  always_comb begin
    enc_sr  = shift_rows(sub_bytes(in_data, 1'b0), 1'b0);
    enc_mix = in_nomix ? enc_sr : mix_columns(enc_sr, 1'b0);
    dec_ark = in_data ^ in_key;
    dec_mix = in_nomix ? dec_ark : mix_columns(dec_ark, 1'b1);
    result  = in_dec ? sub_bytes(shift_rows(dec_mix, 1'b1), 1'b1) : (enc_mix ^ in_key);
  end

  // ---------------------------------------------------------------------------
  // Two-entry elastic buffer
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } occ_t;

  occ_t                    count, count_next;
  logic [BLOCK_LENGTH-1:0] m_data, m_data_next, s_data, s_data_next;
  logic [TAG_WIDTH-1:0]    m_tag, m_tag_next, s_tag, s_tag_next;
  logic                    push, pop;

  assign in_ready  = (count != FULL);
  assign out_valid = (count != EMPTY);
  assign out_data  = m_data;
  assign out_tag   = m_tag;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count  <= EMPTY;
      m_data <= '0;
      m_tag  <= '0;
      s_data <= '0;
      s_tag  <= '0;
    end else begin
      count  <= count_next;
      m_data <= m_data_next;
      m_tag  <= m_tag_next;
      s_data <= s_data_next;
      s_tag  <= s_tag_next;
    end
  end

  // Emptied registers are zeroed so out_data/out_tag read 0 with no extra
  // output gating.
  always_comb begin
    count_next  = count;
    m_data_next = m_data;
    m_tag_next  = m_tag;
    s_data_next = s_data;
    s_tag_next  = s_tag;
    if (flush) begin
      count_next  = EMPTY;
      m_data_next = '0;
      m_tag_next  = '0;
      s_data_next = '0;
      s_tag_next  = '0;
    end else begin
      case (count)
        EMPTY: begin
          if (push) begin
            m_data_next = result;
            m_tag_next  = in_tag;
            count_next  = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            m_data_next = result;
            m_tag_next  = in_tag;
          end else if (push) begin
            s_data_next = result;
            s_tag_next  = in_tag;
            count_next  = FULL;
          end else if (pop) begin
            m_data_next = '0;
            m_tag_next  = '0;
            count_next  = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            m_data_next = s_data;
            m_tag_next  = s_tag;
            s_data_next = '0;
            s_tag_next  = '0;
            count_next  = ONE;
          end
        end
        default: count_next = EMPTY;
      endcase
    end
  end

endmodule
